// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response port bundle shared by both requesters and the bus.
// Master drives the request fields and receives the address/data handshakes.
// Slave accepts the request fields and drives addr_ok/data_ok/rdata back.
`timescale 1ns/1ps
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-requester (inst/data) arbiter onto one SRAM-like bus port, data side has priority.
// Latency: request, addr_ok and data_ok paths are combinational; FIFO/lock update next edge.
// Backpressure: grant locked until addr_ok; m_req held low while MAX_OUTSTANDING ids in flight.
`timescale 1ns/1ps
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  sram_bus_arbiter_if.slave        inst,
  sram_bus_arbiter_if.slave        data,
  sram_bus_arbiter_if.master       m,
  output logic                     err
);

  localparam logic [2:0] CNT_MAX  = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] PTR_LAST = 2'(MAX_OUTSTANDING - 1);

  // Lock state: idle, or grant pinned to one requester until its address is accepted.
  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_state_e;

  lock_state_e state, state_nxt;

  logic       lock_v;
  logic       lock_id;
  logic       grant;
  logic       gnt_req;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       head;
  logic       drop;
  logic       err_set;
  logic [2:0] count;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [3:0] ids;   // outstanding requester ids (0 = inst, 1 = data); only [0..MAX-1] used

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign lock_v  = (state != LK_IDLE);
  assign lock_id = (state == LK_DATA);
  assign full    = (count == CNT_MAX);
  assign empty   = (count == 3'd0);
  assign head    = ids[rd_ptr];

  // Grant selection and request mux towards the bus; data side is the idle default.
  always_comb begin
    grant = 1'b1;
    if (lock_v)
      grant = lock_id;
    else if (inst.req && !data.req)
      grant = 1'b0;

    gnt_req = grant ? data.req : inst.req;
    m.req   = gnt_req && !full && !reset;
    m.wr    = grant ? data.wr    : inst.wr;
    m.size  = grant ? data.size  : inst.size;
    m.wstrb = grant ? data.wstrb : inst.wstrb;
    m.addr  = grant ? data.addr  : inst.addr;
    m.wdata = grant ? data.wdata : inst.wdata;
  end

  // Handshake routing back to the requesters; responses follow the FIFO head.
  always_comb begin
    push = m.req && m.addr_ok;
    pop  = m.data_ok && !empty;

    inst.addr_ok = m.addr_ok && !full && !reset && !grant;
    data.addr_ok = m.addr_ok && !full && !reset && grant;
    inst.data_ok = pop && !reset && !head;
    data.data_ok = pop && !reset && head;
    inst.rdata   = m.rdata;
    data.rdata   = m.rdata;
  end

  // Lock next-state: set on an unaccepted request, cleared on accept or requester drop.
  always_comb begin
    state_nxt = state;
    drop      = 1'b0;
    if (lock_v && !gnt_req) begin
      // Locked requester withdrew before its address was accepted.
      state_nxt = LK_IDLE;
      drop      = 1'b1;
    end else if (push) begin
      state_nxt = LK_IDLE;
    end else if (m.req) begin
      state_nxt = grant ? LK_DATA : LK_INST;
    end
    err_set = drop || (m.data_ok && empty);
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= LK_IDLE;
    else
      state <= state_nxt;
  end

  // Outstanding-id FIFO: push at tail on accept, pop head on response, in-order return.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 3'd0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      ids    <= 4'd0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= grant;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + 3'd1;
      else if (pop && !push)
        count <= count - 3'd1;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (err_set)
      err <= 1'b1;
  end

endmodule
